// File: rtl/uart_bus_master.sv
// Byte-stream command bridge: parses 'W'/'R' frames from a UART receiver and
// drives them as a second initiator on the valid/ready memory bus.
module uart_bus_master #(
  parameter int          BUS_TIMEOUT   = 1024,
  parameter int          FRAME_TIMEOUT = 800000,
  parameter logic [7:0]  ACK_BYTE      = 8'h06,
  parameter logic [7:0]  NAK_BYTE      = 8'h15
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic [7:0]  err_count
);

  localparam int FW = $clog2(FRAME_TIMEOUT + 1);
  localparam int BW = $clog2(BUS_TIMEOUT + 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_TIMEOUT - 1);
  localparam logic [BW-1:0] BUS_LAST   = BW'(BUS_TIMEOUT - 1);
  localparam logic [FW-1:0] FRAME_ONE  = FW'(1);
  localparam logic [BW-1:0] BUS_ONE    = BW'(1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ADDR = 3'd1;
  localparam logic [2:0] DATA = 3'd2;
  localparam logic [2:0] BUS  = 3'd3;
  localparam logic [2:0] RESP = 3'd4;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;

  logic [2:0]    state;
  logic          is_write;
  logic [1:0]    byte_cnt;
  logic [FW-1:0] idle_cnt;
  logic [BW-1:0] bus_cnt;
  logic [1:0]    tx_left;
  logic [31:0]   rdata_sr;

  // Frame parser, bus initiator and response sequencer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      is_write  <= 1'b0;
      byte_cnt  <= 2'd0;
      idle_cnt  <= '0;
      bus_cnt   <= '0;
      tx_left   <= 2'd0;
      rdata_sr  <= 32'h0000_0000;
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
      mem_valid <= 1'b0;
      mem_addr  <= 32'h0000_0000;
      mem_wdata <= 32'h0000_0000;
      mem_wstrb <= 4'h0;
      busy      <= 1'b0;
      err_count <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (rx_valid && (rx_data == OP_WRITE || rx_data == OP_READ)) begin
            state     <= ADDR;
            is_write  <= (rx_data == OP_WRITE);
            mem_wstrb <= (rx_data == OP_WRITE) ? 4'hF : 4'h0;
            byte_cnt  <= 2'd0;
            idle_cnt  <= '0;
            busy      <= 1'b1;
          end
        end
        ADDR: begin
          if (rx_valid) begin
            mem_addr <= {mem_addr[23:0], rx_data};
            idle_cnt <= '0;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (is_write) begin
                state <= DATA;
              end else begin
                state     <= BUS;
                mem_valid <= 1'b1;
                bus_cnt   <= '0;
              end
            end
          end else if (idle_cnt == FRAME_LAST) begin
            // Stale partial frame: drop it silently.
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + FRAME_ONE;
          end
        end
        DATA: begin
          if (rx_valid) begin
            mem_wdata <= {mem_wdata[23:0], rx_data};
            idle_cnt  <= '0;
            byte_cnt  <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state     <= BUS;
              mem_valid <= 1'b1;
              bus_cnt   <= '0;
            end
          end else if (idle_cnt == FRAME_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + FRAME_ONE;
          end
        end
        BUS: begin
          // Ready is checked before the timeout so a last-cycle ready wins.
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state     <= RESP;
            tx_valid  <= 1'b1;
            if (is_write) begin
              tx_data <= ACK_BYTE;
              tx_left <= 2'd0;
            end else begin
              tx_data  <= mem_rdata[31:24];
              rdata_sr <= {mem_rdata[23:0], 8'h00};
              tx_left  <= 2'd3;
            end
          end else if (bus_cnt == BUS_LAST) begin
            mem_valid <= 1'b0;
            state     <= RESP;
            tx_valid  <= 1'b1;
            tx_data   <= NAK_BYTE;
            tx_left   <= 2'd0;
            if (err_count != 8'hFF) begin
              err_count <= err_count + 8'd1;
            end
          end else begin
            bus_cnt <= bus_cnt + BUS_ONE;
          end
        end
        RESP: begin
          if (tx_ready) begin
            if (tx_left == 2'd0) begin
              tx_valid <= 1'b0;
              state    <= IDLE;
              busy     <= 1'b0;
            end else begin
              tx_data  <= rdata_sr[31:24];
              rdata_sr <= {rdata_sr[23:0], 8'h00};
              tx_left  <= tx_left - 2'd1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          tx_valid  <= 1'b0;
          mem_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Randomized self-checking bench for uart_bus_master: a bus responder, a UART
// sink with programmable stalls, and frame-level expectations.
module tb_uart_bus_master;

  localparam int FT = 400;
  localparam int BT = 1024;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  localparam int NEVER = 1000000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        busy;
  logic [7:0]  err_count;

  uart_bus_master #(.BUS_TIMEOUT(BT), .FRAME_TIMEOUT(FT), .ACK_BYTE(ACK), .NAK_BYTE(NAK)) dut (
    .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          len;
    int unsigned start;
  } txn_t;

  int unsigned cyc = 0;
  int unsigned last_rx_cyc = 0;
  txn_t        txq[$];
  logic [7:0]  txb[$];
  txn_t        cur;
  int          vcnt = 0;
  int          lat = 0;
  int          stall = 0;
  int          scnt = 0;
  bit          unstable = 1'b0;
  logic [31:0] rd_value = 32'h0;
  int          n_vec = 0;
  int          n_err = 0;
  int          exp_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus responder: ready during valid cycle number lat+1; records each transaction.
  always @(negedge clk) begin
    if (mem_valid) begin
      if (vcnt == 0) begin
        cur.addr = mem_addr; cur.wdata = mem_wdata; cur.wstrb = mem_wstrb; cur.start = cyc;
      end else if (mem_addr !== cur.addr || mem_wdata !== cur.wdata || mem_wstrb !== cur.wstrb) begin
        unstable = 1'b1;
      end
      vcnt++;
      mem_ready = (vcnt == lat + 1);
      mem_rdata = mem_ready ? rd_value : $urandom;
    end else begin
      if (vcnt != 0) begin
        cur.len = vcnt;
        txq.push_back(cur);
        vcnt = 0;
      end
      mem_ready = 1'b0;
      mem_rdata = $urandom;
    end
  end

  // UART sink: accepts each byte after 'stall' wait cycles.
  always @(negedge clk) begin
    if (tx_valid) begin
      tx_ready = (scnt >= stall);
      if (tx_ready) begin
        txb.push_back(tx_data);
        scnt = 0;
      end else begin
        scnt++;
      end
    end else begin
      tx_ready = ($urandom_range(0, 1) == 1);
      scnt = 0;
    end
  end

  task automatic clear_obs();
    txq.delete();
    txb.delete();
    unstable = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    last_rx_cyc = cyc;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
    send_byte(op);
    for (int i = 0; i < 4; i++) send_byte(8'(a >> (24 - 8 * i)));
    if (op == 8'h57) for (int i = 0; i < 4; i++) send_byte(8'(d >> (24 - 8 * i)));
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy === 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s_idle busy=%b after %0d cycles, required 0", tag, busy, n); end
  endtask

  task automatic check_txn(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int len, input bit chk_data);
    n_vec++; if (txq.size() != 1) begin n_err++; $display("FAIL %s_count got %0d txns, required 1", tag, txq.size()); end
    if (txq.size() >= 1) begin
      n_vec++; if (txq[0].addr !== a) begin n_err++; $display("FAIL %s_addr got %h required %h", tag, txq[0].addr, a); end
      n_vec++; if (txq[0].wstrb !== s) begin n_err++; $display("FAIL %s_wstrb got %h required %h", tag, txq[0].wstrb, s); end
      n_vec++; if (txq[0].len != len) begin n_err++; $display("FAIL %s_len got %0d required %0d", tag, txq[0].len, len); end
      if (chk_data) begin
        n_vec++; if (txq[0].wdata !== d) begin n_err++; $display("FAIL %s_wdata got %h required %h", tag, txq[0].wdata, d); end
      end
    end
    n_vec++; if (unstable) begin n_err++; $display("FAIL %s_stable got unstable=1 required 0", tag); end
  endtask

  task automatic test_reset();
    n_vec++; if (mem_valid !== 1'b0) begin n_err++; $display("FAIL reset_mem_valid got %b required 0", mem_valid); end
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid got %b required 0", tx_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b required 0", busy); end
    n_vec++; if (err_count !== 8'h00) begin n_err++; $display("FAIL reset_err_count got %h required 00", err_count); end
    n_vec++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_mem_addr got %h required 0", mem_addr); end
    n_vec++; if (mem_wstrb !== 4'h0) begin n_err++; $display("FAIL reset_mem_wstrb got %h required 0", mem_wstrb); end
    n_vec++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data got %h required 00", tx_data); end
  endtask

  task automatic test_write(input logic [31:0] a, input logic [31:0] d, input int l, input int s);
    clear_obs();
    lat = l; stall = s;
    send_frame(8'h57, a, d);
    wait_idle(200, "write");
    check_txn("write", a, d, 4'hF, l + 1, 1'b1);
    if (txq.size() >= 1) begin
      n_vec++; if (txq[0].start - last_rx_cyc != 1) begin n_err++; $display("FAIL write_latency got %0d required 1", txq[0].start - last_rx_cyc); end
    end
    n_vec++; if (txb.size() != 1 || txb[0] !== ACK) begin n_err++; $display("FAIL write_resp got %0d bytes first %h required 1 byte 06", txb.size(), txb.size() > 0 ? txb[0] : 8'hxx); end
  endtask

  task automatic test_read(input logic [31:0] a, input logic [31:0] rd, input int l, input int s);
    clear_obs();
    lat = l; stall = s; rd_value = rd;
    send_frame(8'h52, a, 32'h0);
    wait_idle(300, "read");
    check_txn("read", a, 32'h0, 4'h0, l + 1, 1'b0);
    n_vec++; if (txb.size() != 4) begin n_err++; $display("FAIL read_resp_len got %0d required 4", txb.size()); end
    for (int i = 0; i < 4 && i < txb.size(); i++) begin
      n_vec++; if (txb[i] !== 8'(rd >> (24 - 8 * i))) begin n_err++; $display("FAIL read_byte%0d got %h required %h", i, txb[i], 8'(rd >> (24 - 8 * i))); end
    end
  endtask

  task automatic test_bus_timeout();
    clear_obs();
    lat = NEVER; stall = $urandom_range(0, 3);
    send_frame(8'h52, $urandom, 32'h0);
    wait_idle(BT + 100, "timeout");
    exp_err = (exp_err < 255) ? exp_err + 1 : 255;
    n_vec++; if (txq.size() != 1 || txq[0].len != BT) begin n_err++; $display("FAIL timeout_len got %0d txns len %0d required 1 txn len %0d", txq.size(), txq.size() > 0 ? txq[0].len : 0, BT); end
    n_vec++; if (txb.size() != 1 || txb[0] !== NAK) begin n_err++; $display("FAIL timeout_resp got %0d bytes first %h required 1 byte 15", txb.size(), txb.size() > 0 ? txb[0] : 8'hxx); end
    n_vec++; if (err_count !== 8'(exp_err)) begin n_err++; $display("FAIL timeout_err_count got %0d required %0d", err_count, exp_err); end
  endtask

  task automatic test_ready_last_cycle();
    clear_obs();
    lat = BT - 1; stall = 0; rd_value = $urandom;
    send_frame(8'h52, 32'h0000_0040, 32'h0);
    wait_idle(BT + 100, "lastready");
    n_vec++; if (txb.size() != 4) begin n_err++; $display("FAIL lastready_resp got %0d bytes required 4", txb.size()); end
    n_vec++; if (err_count !== 8'(exp_err)) begin n_err++; $display("FAIL lastready_err_count got %0d required %0d", err_count, exp_err); end
  endtask

  task automatic test_frame_timeout();
    logic [31:0] a;
    clear_obs();
    send_byte(8'h57); send_byte(8'h10); send_byte(8'h00);
    repeat (FT + 10) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL frame_timeout_busy got %b required 0", busy); end
    n_vec++; if (txq.size() != 0 || txb.size() != 0) begin n_err++; $display("FAIL frame_timeout_quiet got %0d txns %0d bytes required 0 0", txq.size(), txb.size()); end
    test_read($urandom, $urandom, $urandom_range(0, 5), $urandom_range(0, 2));
    // A gap just short of the timeout must not discard the frame.
    clear_obs();
    a = $urandom; lat = 1; stall = 0; rd_value = $urandom;
    send_byte(8'h52); send_byte(a[31:24]);
    repeat (FT - 20) @(negedge clk);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL frame_hold_busy got %b required 1", busy); end
    send_byte(a[23:16]); send_byte(a[15:8]); send_byte(a[7:0]);
    wait_idle(100, "frame_hold");
    check_txn("frame_hold", a, 32'h0, 4'h0, 2, 1'b0);
  endtask

  task automatic test_garbage();
    clear_obs();
    lat = 2; stall = 1; rd_value = $urandom;
    send_byte(8'h41); send_byte(8'hFF);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL garbage_busy got %b required 0", busy); end
    send_frame(8'h52, 32'h0000_0008, 32'h0);
    wait_idle(100, "garbage");
    check_txn("garbage", 32'h0000_0008, 32'h0, 4'h0, 3, 1'b0);
  endtask

  task automatic test_rx_drop();
    clear_obs();
    lat = 15; stall = 2; rd_value = $urandom;
    send_frame(8'h52, 32'h0000_0100, 32'h0);
    send_byte(8'h57); send_byte(8'h52);
    wait_idle(100, "rx_drop");
    check_txn("rx_drop", 32'h0000_0100, 32'h0, 4'h0, 16, 1'b0);
    n_vec++; if (txb.size() != 4) begin n_err++; $display("FAIL rx_drop_resp got %0d bytes required 4", txb.size()); end
  endtask

  task automatic test_reset_mid();
    int n;
    clear_obs();
    lat = NEVER;
    send_frame(8'h52, $urandom, 32'h0);
    repeat (10) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    n_vec++; if (mem_valid !== 1'b0) begin n_err++; $display("FAIL rst_bus_mem_valid got %b required 0", mem_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_bus_busy got %b required 0", busy); end
    n_vec++; if (err_count !== 8'h00) begin n_err++; $display("FAIL rst_bus_err_count got %h required 00", err_count); end
    @(negedge clk) resetn = 1'b1;
    exp_err = 0;
    // Reset while a response byte is waiting for the transmitter.
    clear_obs();
    lat = 0; stall = 40; rd_value = $urandom;
    send_frame(8'h52, $urandom, 32'h0);
    n = 0;
    while (tx_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    n_vec++; if (tx_valid !== 1'b1) begin n_err++; $display("FAIL rst_resp_reach got tx_valid=%b required 1", tx_valid); end
    #2 resetn = 1'b0;
    #1;
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_tx_valid got %b required 0", tx_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_resp_busy got %b required 0", busy); end
    @(negedge clk) resetn = 1'b1;
    test_write($urandom, $urandom, $urandom_range(0, 4), $urandom_range(0, 2));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    resetn = 1'b1;
    @(negedge clk);
    test_reset();
    test_write(32'h1000_0004, 32'hDEAD_BEEF, 2, 0);
    test_read(32'h0000_0100, 32'h1234_5678, 3, 5);
    for (int i = 0; i < 6; i++) begin
      test_write($urandom, $urandom, $urandom_range(0, 8), $urandom_range(0, 4));
      test_read($urandom, $urandom, $urandom_range(0, 8), $urandom_range(0, 4));
    end
    test_bus_timeout();
    test_ready_last_cycle();
    test_frame_timeout();
    test_garbage();
    test_rx_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
